// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-requester write-port arbiter for the 8x8 register file
module regfile_wr_arbiter #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic              last_grant,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic both_valid;
  logic pick0;
  logic grant0;
  logic grant1;

  // Combinational grant: on contention req0 wins in fixed mode, otherwise whoever did not win last
  always_comb begin
    both_valid = req0_valid & req1_valid;
    pick0      = (FIXED_PRIO != 0) || last_grant;
    grant0     = !reset && !hold && req0_valid && (!req1_valid || pick0);
    grant1     = !reset && !hold && req1_valid && (!req0_valid || !pick0);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Register the granted write toward the regfile, track the winner and count contention cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we        <= 1'b0;
      rf_w_addr    <= '0;
      rf_w_data    <= '0;
      last_grant   <= 1'b1;
      conflict_cnt <= '0;
    end else begin
      rf_we <= grant0 | grant1;
      if (grant0) begin
        rf_w_addr  <= req0_addr;
        rf_w_data  <= req0_data;
        last_grant <= 1'b0;
      end else if (grant1) begin
        rf_w_addr  <= req1_addr;
        rf_w_data  <= req1_data;
        last_grant <= 1'b1;
      end
      if (both_valid && !hold && conflict_cnt != CNT_MAX) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed scoreboard bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

  logic       clk = 1'b0;
  logic       reset, hold;
  logic       v0, v1, r0, r1;
  logic [2:0] a0, a1, rf_w_addr;
  logic [7:0] d0, d1, rf_w_data, conflict_cnt;
  logic       rf_we, last_grant;

  logic       b_v0, b_v1, b_r0, b_r1, b_we, b_lg;
  logic [2:0] b_a0, b_a1, b_wa;
  logic [7:0] b_d0, b_d1, b_wd, b_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed { logic [2:0] addr; logic [7:0] data; } wr_t;
  wr_t        src0[$], src1[$], exp_q[$];
  logic [1:0] glog[$];
  logic       mlast;
  logic [7:0] mcnt;
  logic [7:0] rf_mem[8];

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.ADDR_W(3), .DATA_W(8), .FIXED_PRIO(0), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1),
    .rf_we(rf_we), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .last_grant(last_grant), .conflict_cnt(conflict_cnt)
  );

  regfile_wr_arbiter #(.ADDR_W(3), .DATA_W(8), .FIXED_PRIO(1), .CNT_W(8)) dut_fixed (
    .clk(clk), .reset(reset), .hold(hold),
    .req0_valid(b_v0), .req0_addr(b_a0), .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_addr(b_a1), .req1_data(b_d1), .req1_ready(b_r1),
    .rf_we(b_we), .rf_w_addr(b_wa), .rf_w_data(b_wd),
    .last_grant(b_lg), .conflict_cnt(b_cnt)
  );

  // behavioural register file fed by the arbiter's write port
  always @(posedge clk) begin
    if (rf_we === 1'b1) rf_mem[rf_w_addr] <= rf_w_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] model_grant(input logic rv0, input logic rv1);
    if (reset || hold) return 2'b00;
    if (rv0 && rv1)    return mlast ? 2'b01 : 2'b10;
    if (rv0)           return 2'b01;
    if (rv1)           return 2'b10;
    return 2'b00;
  endfunction

  // one clock: present heads of the source queues, check grants, then check the registered write
  task automatic cycle();
    logic [1:0] g;
    wr_t        e;
    v0 = (src0.size() != 0);
    v1 = (src1.size() != 0);
    if (v0) begin a0 = src0[0].addr; d0 = src0[0].data; end
    if (v1) begin a1 = src1[0].addr; d1 = src1[0].data; end
    #1;
    g = model_grant(v0, v1);
    chk("req0_ready", r0, g[0]);
    chk("req1_ready", r1, g[1]);
    chk("ready_overlap", r0 & r1, 0);
    glog.push_back({r1, r0});
    if (reset) begin
      mlast = 1'b1;
      mcnt  = 8'h00;
      exp_q.delete();
    end else begin
      if (v0 && v1 && !hold && mcnt != 8'hFF) mcnt++;
      if (g[0]) begin
        exp_q.push_back(src0.pop_front());
        mlast = 1'b0;
      end else if (g[1]) begin
        exp_q.push_back(src1.pop_front());
        mlast = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("rf_we", rf_we, (g != 2'b00));
    if (g != 2'b00) begin
      if (exp_q.size() == 0) chk("scoreboard_underflow", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rf_w_addr", rf_w_addr, e.addr);
        chk("rf_w_data", rf_w_data, e.data);
      end
    end
    if (reset) begin
      chk("rst_w_addr", rf_w_addr, 0);
      chk("rst_w_data", rf_w_data, 0);
    end
    chk("last_grant", last_grant, mlast);
    chk("conflict_cnt", conflict_cnt, mcnt);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    foreach (rf_mem[i]) rf_mem[i] = 8'h00;
    reset = 1'b1; hold = 1'b0;
    v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    b_v0 = 0; b_v1 = 0; b_a0 = 0; b_a1 = 0; b_d0 = 0; b_d1 = 0;
    mlast = 1'b1; mcnt = 8'h00;
    @(negedge clk);
    run(2);
    chk("reset_we", rf_we, 0);
    chk("reset_last_grant", last_grant, 1);
    chk("reset_cnt", conflict_cnt, 0);
    reset = 1'b0;

    // single ALU write R1=AA, then read back through the regfile
    src0.push_back('{addr: 3'd1, data: 8'hAA});
    run(1);
    chk("single_last_grant", last_grant, 0);
    run(1);
    chk("regfile_R1", rf_mem[1], 8'hAA);

    // first contention after reset: req0 wins, then req1
    reset = 1'b1; run(1); reset = 1'b0;
    glog.delete();
    src0.push_back('{addr: 3'd2, data: 8'h55});
    src1.push_back('{addr: 3'd3, data: 8'hC3});
    run(3);
    chk("contend_order0", glog[0], 2'b01);
    chk("contend_order1", glog[1], 2'b10);
    chk("contend_cnt", conflict_cnt, 1);
    chk("regfile_R2", rf_mem[2], 8'h55);
    chk("regfile_R3", rf_mem[3], 8'hC3);

    // sustained dual requests alternate 0,1,0,1,0,1
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      src0.push_back('{addr: 3'(i), data: 8'h10 + 8'(i)});
      src1.push_back('{addr: 3'(i + 4), data: 8'h20 + 8'(i)});
    end
    run(6);
    for (int i = 0; i < 6; i++) chk($sformatf("alt_grant%0d", i), glog[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    run(3);
    chk("alt_src_drained", src0.size() + src1.size(), 0);
    chk("alt_scoreboard_empty", exp_q.size(), 0);

    // fixed priority: req1 starves while req0 stays valid
    b_v0 = 1; b_v1 = 1; b_a0 = 3'd5; b_d0 = 8'h5A; b_a1 = 3'd6; b_d1 = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fixed_ready0", b_r0, 1);
      chk("fixed_ready1_starved", b_r1, 0);
      cycle();
      chk("fixed_wd0", b_wd, 8'h5A);
    end
    b_v0 = 0;
    #1;
    chk("fixed_ready1_after_drop", b_r1, 1);
    chk("fixed_ready0_after_drop", b_r0, 0);
    cycle();
    b_v1 = 0;
    chk("fixed_wa1", b_wa, 3'd6);
    chk("fixed_wd1", b_wd, 8'hA5);
    chk("fixed_last_grant", b_lg, 1);

    // hold blocks grants; release gives exactly one write of R4=0F
    hold = 1'b1;
    src1.push_back('{addr: 3'd4, data: 8'h0F});
    run(3);
    hold = 1'b0;
    run(1);
    run(1);
    chk("hold_single_write", rf_we, 0);
    chk("regfile_R4", rf_mem[4], 8'h0F);

    // long contention saturates the counter
    for (int i = 0; i < 160; i++) begin
      src0.push_back('{addr: 3'(i), data: 8'(i)});
      src1.push_back('{addr: 3'(i), data: ~8'(i)});
    end
    run(300);
    chk("cnt_saturated", conflict_cnt, 8'hFF);
    chk("inflight_we", rf_we, 1);

    // reset mid-stream with req0 still valid
    reset = 1'b1;
    run(1);
    chk("midrst_we", rf_we, 0);
    chk("midrst_cnt", conflict_cnt, 0);
    chk("midrst_last_grant", last_grant, 1);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
